// File: rtl/wb_rvseed_pkg.sv
// Shared RVSEED write-back definitions: regfile port widths, load funct3 codes,
// FSM encoding and the latched load context.
package wb_rvseed_pkg;

  localparam int REG_ADDR_WIDTH = 7;   // byte offsets 0x00..0x7C
  localparam int REG_DATA_WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } load_ctx_t;

endpackage

// File: rtl/wb_rvseed_load_align.sv
// Combinational load aligner: picks byte/half/word out of the raw memory word
// and sign- or zero-extends it. Kept standalone so the LSU can reuse it.
module load_align_rvseed
  import wb_rvseed_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Misaligned halves silently drop addr bit 0; no trap is raised here.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LHU:  data = {16'b0, half_sel};
      default: data = rdata;   // LW and undefined encodings
    endcase
  end

endmodule

// File: rtl/wb_rvseed.sv
// RVSEED write-back stage: retires ALU results immediately, parks loads until
// the memory response (or a timeout), and drives the registered regfile write.
module wb_rvseed
  import wb_rvseed_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 64,
  parameter int TO_CNT_W     = 7
) (
  input  logic                      clk_reg,
  input  logic                      rst_reg_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [4:0]                ex_rd,
  input  logic                      ex_is_load,
  input  logic [2:0]                ex_funct3,
  input  logic [1:0]                ex_addr_lo,
  input  logic [31:0]               ex_result,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [REG_DATA_WIDTH-1:0] reg_wdata,
  output logic                      load_pending,
  output logic [4:0]                load_rd,
  output logic                      load_err
);

  wb_state_e                 state_q, state_d;
  logic [TO_CNT_W-1:0]       cnt_q, cnt_d;
  load_ctx_t                 ctx_q, ctx_d;
  logic                      reg_wen_q, reg_wen_d;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [REG_DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                      load_err_q, load_err_d;
  logic [31:0]               aligned;
  logic                      xfer;

  load_align_rvseed u_align (
    .funct3  (ctx_q.funct3),
    .addr_lo (ctx_q.addr_lo),
    .rdata   (mem_rdata),
    .data    (aligned)
  );

  assign ex_ready = (state_q == ST_IDLE);
  assign xfer     = ex_valid & ex_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctx_d       = ctx_q;
    reg_wen_d   = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    load_err_d  = load_err_q;
    case (state_q)
      ST_IDLE: begin
        // A response with nothing outstanding is a protocol error, never a write.
        if (mem_rvalid) load_err_d = 1'b1;
        if (xfer) begin
          if (ex_is_load) begin
            ctx_d   = '{rd: ex_rd, funct3: ex_funct3, addr_lo: ex_addr_lo};
            cnt_d   = '0;
            state_d = ST_WAIT_LOAD;
          end else if (ex_rd != 5'd0) begin
            reg_wen_d   = 1'b1;
            reg_waddr_d = REG_ADDR_WIDTH'({ex_rd, 2'b00});
            reg_wdata_d = ex_result;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (ctx_q.rd != 5'd0) begin
            reg_wen_d   = 1'b1;
            reg_waddr_d = REG_ADDR_WIDTH'({ctx_q.rd, 2'b00});
            reg_wdata_d = aligned;
          end
        end else if (cnt_q == TO_CNT_W'(LOAD_TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_reg or negedge rst_reg_n) begin
    if (!rst_reg_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ctx_q       <= '0;
      reg_wen_q   <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctx_q       <= ctx_d;
      reg_wen_q   <= reg_wen_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      load_err_q  <= load_err_d;
    end
  end

  assign reg_wen      = reg_wen_q;
  assign reg_waddr    = reg_waddr_q;
  assign reg_wdata    = reg_wdata_q;
  assign load_err     = load_err_q;
  assign load_pending = (state_q == ST_WAIT_LOAD);
  assign load_rd      = load_pending ? ctx_q.rd : 5'd0;

endmodule

// File: tb/tb_wb_rvseed.sv
// Scoreboard bench for wb_rvseed: stimulus pushes expected regfile writes,
// a negedge monitor pops and compares every reg_wen pulse.
module tb_wb_rvseed;

  logic        clk_reg = 1'b0;
  logic        rst_reg_n;
  logic        ex_valid, ex_ready, ex_is_load;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_wen;
  logic [6:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        load_pending, load_err;
  logic [4:0]  load_rd;

  typedef struct { logic [6:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  wb_rvseed #(.LOAD_TIMEOUT(64), .TO_CNT_W(7)) dut (
    .clk_reg(clk_reg), .rst_reg_n(rst_reg_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .ex_result(ex_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .load_pending(load_pending), .load_rd(load_rd), .load_err(load_err)
  );

  always #5 clk_reg = ~clk_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_reg);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    wr_t w;
    w.a = {rd, 2'b00};
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk_reg) begin
    if (rst_reg_n && reg_wen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(reg_waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(reg_waddr), 32'(w.a));
        chk("wr_data", reg_wdata, w.d);
      end
    end
  end

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_result = res;
    if (rd != 5'd0) push(rd, res);
  endtask

  // Issue a load, answer it after `gap` idle wait cycles. With `hold`, EX keeps
  // an ALU op (rd=6) presented during the wait; it must retire only afterwards.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] rdata, input int gap, input logic [31:0] exp_d,
                         input bit hold);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_funct3 = f3;
    ex_addr_lo = lo; ex_result = 32'hDEAD_BEEF;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("load_pending_set", 32'(load_pending), 32'd1);
    chk("load_rd_set", 32'(load_rd), 32'(rd));
    if (hold) begin
      ex_valid = 1'b1; ex_rd = 5'd6; ex_result = 32'h0000_0066;
    end
    repeat (gap) begin
      chk("ex_ready_wait", 32'(ex_ready), 32'd0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    if (rd != 5'd0) push(rd, exp_d);
    if (hold) push(5'd6, 32'h0000_0066);
    tick();
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    chk("ex_ready_after_rsp", 32'(ex_ready), 32'd1);
    chk("reg_wen_load", 32'(reg_wen), {31'b0, rd != 5'd0});
    chk("load_pending_clr", 32'(load_pending), 32'd0);
    chk("load_rd_clr", 32'(load_rd), 32'd0);
    if (hold) begin
      tick();
      ex_valid = 1'b0;
      chk("held_alu_wen", 32'(reg_wen), 32'd1);
    end
  endtask

  initial begin
    rst_reg_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    ex_funct3 = '0; ex_addr_lo = '0; ex_result = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_reg_wen", 32'(reg_wen), 32'd0);
    chk("rst_waddr", 32'(reg_waddr), 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_pending", 32'(load_pending), 32'd0);
    chk("rst_load_rd", 32'(load_rd), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    #10 rst_reg_n = 1'b1;
    tick();

    // 1: back-to-back ALU retirements
    alu(5'd1, 32'hAAAA_0001); tick(); chk("alu1_wen", 32'(reg_wen), 32'd1);
    alu(5'd2, 32'hBBBB_0002); tick(); chk("alu2_wen", 32'(reg_wen), 32'd1);
    alu(5'd3, 32'hCCCC_0003); tick(); chk("alu3_wen", 32'(reg_wen), 32'd1);
    ex_valid = 1'b0; tick();
    chk("alu_wen_pulse", 32'(reg_wen), 32'd0);

    // 2: LB, response 4 cycles after accept, with EX held off meanwhile
    do_load(5'd5, 3'b000, 2'd3, 32'h80FF_1234, 3, 32'hFFFF_FF80, 1'b1);

    // 3: alignment / extension vectors
    do_load(5'd7,  3'b101, 2'd2, 32'h9876_5432, 1, 32'h0000_9876, 1'b0); // LHU
    do_load(5'd7,  3'b001, 2'd2, 32'h9876_5432, 0, 32'hFFFF_9876, 1'b0); // LH
    do_load(5'd7,  3'b010, 2'd0, 32'h9876_5432, 2, 32'h9876_5432, 1'b0); // LW
    do_load(5'd8,  3'b001, 2'd3, 32'h9876_5432, 0, 32'hFFFF_9876, 1'b0); // LH, bit0 ignored
    do_load(5'd9,  3'b100, 2'd0, 32'h9876_5432, 0, 32'h0000_0032, 1'b0); // LBU
    do_load(5'd10, 3'b000, 2'd1, 32'h80FF_1234, 0, 32'h0000_0012, 1'b0); // LB positive
    do_load(5'd31, 3'b110, 2'd1, 32'h1357_9BDF, 0, 32'h1357_9BDF, 1'b0); // undefined -> LW

    // 4: rd=0 never writes
    alu(5'd0, 32'h1234_5678); tick(); ex_valid = 1'b0;
    chk("alu_x0_wen", 32'(reg_wen), 32'd0);
    do_load(5'd0, 3'b010, 2'd0, 32'hFFFF_FFFF, 2, 32'h0, 1'b0);
    chk("err_clean_before_timeout", 32'(load_err), 32'd0);

    // 5: timeout after 64 cycles in WAIT_LOAD, then stray response in IDLE
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; ex_funct3 = 3'b010;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    repeat (63) tick();
    chk("to_still_pending", 32'(load_pending), 32'd1);
    chk("to_no_err_yet", 32'(load_err), 32'd0);
    tick();
    chk("to_pending_clr", 32'(load_pending), 32'd0);
    chk("to_ex_ready", 32'(ex_ready), 32'd1);
    chk("to_load_err", 32'(load_err), 32'd1);
    chk("to_no_write", 32'(reg_wen), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_err_sticky", 32'(load_err), 32'd1);
    chk("stray_no_write", 32'(reg_wen), 32'd0);

    // 6: asynchronous reset in the middle of a pending load
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd11; ex_funct3 = 3'b010;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("pre_rst_pending", 32'(load_pending), 32'd1);
    #3 rst_reg_n = 1'b0;
    #1;
    chk("arst_reg_wen", 32'(reg_wen), 32'd0);
    chk("arst_waddr", 32'(reg_waddr), 32'd0);
    chk("arst_wdata", reg_wdata, 32'd0);
    chk("arst_pending", 32'(load_pending), 32'd0);
    chk("arst_load_rd", 32'(load_rd), 32'd0);
    chk("arst_load_err", 32'(load_err), 32'd0);
    @(negedge clk_reg); #1 rst_reg_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rsp_err", 32'(load_err), 32'd1);
    chk("late_rsp_no_write", 32'(reg_wen), 32'd0);
    do_load(5'd12, 3'b010, 2'd0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0);

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
